// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-side bus between the REG/DEC stage and the hazard/forwarding controller.
// The stage (master) drives the decoded controls; the controller (slave) returns
// forwarding selects, stall/bubble and the event counters.
interface hazard_fwd_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr;
    logic             Reg2Loc;
    logic [1:0]       ALUSrc;
    logic             RegWriteIn;
    logic             Mem2RegIn;
    logic             br_taken;
    logic [1:0]       ForwardMuxA;
    logic [1:0]       ForwardMuxB;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output instr, Reg2Loc, ALUSrc, RegWriteIn, Mem2RegIn, br_taken,
        input  ForwardMuxA, ForwardMuxB, stall, bubble, stall_cnt, flush_cnt
    );

    modport slave (
        input  instr, Reg2Loc, ALUSrc, RegWriteIn, Mem2RegIn, br_taken,
        output ForwardMuxA, ForwardMuxB, stall, bubble, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | normal issue; forwarding active, hazards/branches detected
//   STALL | one cycle after a load-use bubble; load now in MEM
//   FLUSH | squashing decode slots after a taken branch (flush_q left)
//
// Selects, stall and bubble are combinational from state, tags and inputs so
// they settle within the REG/DEC cycle. A shadow pipeline of destination tags
// tracks what sits in EX and MEM.
module hazard_fwd_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic           clk,
    input logic           reset,
    hazard_fwd_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } tag_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       flush_q, flush_d;
    tag_t             ex_tag_q, ex_tag_d;
    tag_t             mem_tag_q, mem_tag_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [4:0] src_a, src_b;
    logic       use_b, load_use;
    logic       stall_o, bubble_o;
    logic [1:0] fwd_a, fwd_b;
    logic       unused_instr_bits;

    // X31 is the zero register: never a forwarding or stall source.
    function automatic logic tag_hit(tag_t t, logic [4:0] src);
        return t.valid && (t.rd == src) && (t.rd != 5'd31);
    endfunction

    assign unused_instr_bits = ^{bus.instr[31:21], bus.instr[15:10]};

    // Source decode and load-use detection.
    always_comb begin
        src_a    = bus.instr[9:5];
        src_b    = bus.Reg2Loc ? bus.instr[20:16] : bus.instr[4:0];
        use_b    = (bus.ALUSrc == 2'b00);
        load_use = ex_tag_q.is_load &&
                   (tag_hit(ex_tag_q, src_a) || (use_b && tag_hit(ex_tag_q, src_b)));
    end

    // Next state, stall/bubble; a taken branch beats a load-use hazard.
    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        stall_o  = 1'b0;
        bubble_o = 1'b0;
        case (state_q)
            FLUSH: begin
                bubble_o = 1'b1;
                if (bus.br_taken) begin
                    flush_d = FLUSH_LOAD;
                    state_d = (FLUSH_LOAD == 2'd0) ? RUN : FLUSH;
                end else begin
                    flush_d = flush_q - 2'd1;
                    state_d = (flush_q <= 2'd1) ? RUN : FLUSH;
                end
            end
            default: begin
                // STALL shares RUN's decisions: the bubble now sits in EX, so a
                // fresh hazard can only come from a new instruction.
                if (bus.br_taken) begin
                    bubble_o = 1'b1;
                    flush_d  = FLUSH_LOAD;
                    state_d  = (FLUSH_LOAD == 2'd0) ? RUN : FLUSH;
                end else if (load_use) begin
                    stall_o  = 1'b1;
                    bubble_o = 1'b1;
                    state_d  = STALL;
                end else begin
                    state_d  = RUN;
                end
            end
        endcase
    end

    // Forwarding selects; EX beats MEM, a load in EX is never an EX source.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!bubble_o) begin
            if (tag_hit(ex_tag_q, src_a) && !ex_tag_q.is_load) fwd_a = 2'b01;
            else if (tag_hit(mem_tag_q, src_a))                fwd_a = 2'b10;
            if (use_b) begin
                if (tag_hit(ex_tag_q, src_b) && !ex_tag_q.is_load) fwd_b = 2'b01;
                else if (tag_hit(mem_tag_q, src_b))                fwd_b = 2'b10;
            end
        end
    end

    // Tag shift and saturating event counters.
    always_comb begin
        ex_tag_d.valid   = bus.RegWriteIn & ~bubble_o;
        ex_tag_d.rd      = bus.instr[4:0];
        ex_tag_d.is_load = bus.Mem2RegIn;
        mem_tag_d        = ex_tag_q;
        stall_cnt_d      = stall_cnt_q;
        flush_cnt_d      = flush_cnt_q;
        if (stall_o && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (bubble_o && !stall_o && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            flush_q     <= 2'd0;
            ex_tag_q    <= '0;
            mem_tag_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            ex_tag_q    <= ex_tag_d;
            mem_tag_q   <= mem_tag_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ForwardMuxA = fwd_a;
    assign bus.ForwardMuxB = fwd_b;
    assign bus.stall       = stall_o;
    assign bus.bubble      = bubble_o;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;
    localparam int FC = 2;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.CNT_W(CW)) bus ();
    hazard_fwd_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rd, rn, rm;
        logic       r2l;
        logic [1:0] alu;
        logic       rw, m2r, br;
        logic [1:0] fa, fb;
        logic       st, bub;
    } vec_t;

    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } prod_t;

    vec_t  tbl[15];
    prod_t m_ex, m_mem;
    int    m_flush_left, m_stall_cnt, m_flush_cnt;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(logic [4:0] rd, logic [4:0] rn, logic [4:0] rm);
        logic [31:0] w;
        w = $urandom;
        w[4:0]   = rd;
        w[9:5]   = rn;
        w[20:16] = rm;
        return w;
    endfunction

    function automatic vec_t v(logic [4:0] rd, logic [4:0] rn, logic [4:0] rm, logic r2l,
                               logic [1:0] alu, logic rw, logic m2r, logic br,
                               logic [1:0] fa, logic [1:0] fb, logic st, logic bub);
        vec_t r;
        r.rd = rd; r.rn = rn; r.rm = rm; r.r2l = r2l; r.alu = alu; r.rw = rw;
        r.m2r = m2r; r.br = br; r.fa = fa; r.fb = fb; r.st = st; r.bub = bub;
        return r;
    endfunction

    task automatic drive(logic [31:0] ins, logic r2l, logic [1:0] alu, logic rw,
                         logic m2r, logic br);
        bus.instr      = ins;
        bus.Reg2Loc    = r2l;
        bus.ALUSrc     = alu;
        bus.RegWriteIn = rw;
        bus.Mem2RegIn  = m2r;
        bus.br_taken   = br;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit feeds(prod_t p, logic [4:0] r);
        return p.v && (p.rd == r) && (r != 5'd31);
    endfunction

    task automatic check_idle(string nm);
        chk({nm, "_fa"}, 32'(bus.ForwardMuxA), 0);
        chk({nm, "_fb"}, 32'(bus.ForwardMuxB), 0);
        chk({nm, "_stall"}, 32'(bus.stall), 0);
        chk({nm, "_bubble"}, 32'(bus.bubble), 0);
        chk({nm, "_stall_cnt"}, 32'(bus.stall_cnt), 0);
        chk({nm, "_flush_cnt"}, 32'(bus.flush_cnt), 0);
    endtask

    // Hold reset across an edge, then release away from the clock edge.
    task automatic do_reset();
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_ex = '0; m_mem = '0;
        m_flush_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        step();
    endtask

    // Reference: a two-deep history of producers plus a count of decode
    // slots still to be squashed; outputs follow the pipeline rules directly.
    task automatic model_check(int cyc);
        logic [4:0] sa, sb;
        bit         useb, hz, est, ebub;
        logic [1:0] efa, efb;
        string      nm;
        nm   = $sformatf("rand%0d", cyc);
        sa   = bus.instr[9:5];
        sb   = bus.Reg2Loc ? bus.instr[20:16] : bus.instr[4:0];
        useb = (bus.ALUSrc == 2'b00);
        hz   = m_ex.ld && (feeds(m_ex, sa) || (useb && feeds(m_ex, sb)));
        est = 0; ebub = 0;
        if (m_flush_left > 0 || bus.br_taken) ebub = 1;
        else if (hz) begin est = 1; ebub = 1; end
        efa = 2'b00; efb = 2'b00;
        if (!ebub) begin
            if (feeds(m_ex, sa) && !m_ex.ld) efa = 2'b01;
            else if (feeds(m_mem, sa))       efa = 2'b10;
            if (useb) begin
                if (feeds(m_ex, sb) && !m_ex.ld) efb = 2'b01;
                else if (feeds(m_mem, sb))       efb = 2'b10;
            end
        end
        chk({nm, "_fa"}, 32'(bus.ForwardMuxA), 32'(efa));
        chk({nm, "_fb"}, 32'(bus.ForwardMuxB), 32'(efb));
        chk({nm, "_stall"}, 32'(bus.stall), 32'(est));
        chk({nm, "_bubble"}, 32'(bus.bubble), 32'(ebub));
        chk({nm, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall_cnt));
        chk({nm, "_flush_cnt"}, 32'(bus.flush_cnt), 32'(m_flush_cnt));
        if (bus.br_taken)          m_flush_left = FC - 1;
        else if (m_flush_left > 0) m_flush_left--;
        if (est && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (ebub && !est && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        m_mem = m_ex;
        m_ex  = '{v: bus.RegWriteIn && !ebub, rd: bus.instr[4:0], ld: bus.Mem2RegIn};
    endtask

    function automatic logic [4:0] rreg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    initial begin
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        //          rd  rn  rm r2l alu rw m2r br  fa  fb st bub
        tbl[0]  = v(5,  0,  1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(6,  5,  2, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        tbl[2]  = v(7,  1,  6, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        tbl[3]  = v(8,  6,  3, 1, 0, 1, 0, 0, 2, 0, 0, 0);
        tbl[4]  = v(3,  1,  0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        tbl[5]  = v(4,  3,  2, 1, 0, 1, 0, 0, 0, 0, 1, 1);
        tbl[6]  = v(4,  3,  2, 1, 0, 1, 0, 0, 2, 0, 0, 0);
        tbl[7]  = v(31, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[8]  = v(9,  31, 31, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = v(10, 0,  9, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        tbl[10] = v(12, 10, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
        tbl[11] = v(13, 12, 12, 1, 0, 1, 0, 1, 0, 0, 0, 1);
        tbl[12] = v(14, 12, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        tbl[13] = v(15, 12, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[14] = v(16, 15, 15, 1, 0, 1, 0, 0, 1, 1, 0, 0);

        #12;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b1;
        step();

        // Directed pipeline sequence from a clean reset.
        for (int i = 0; i < 15; i++) begin
            drive(mk(tbl[i].rd, tbl[i].rn, tbl[i].rm), tbl[i].r2l, tbl[i].alu,
                  tbl[i].rw, tbl[i].m2r, tbl[i].br);
            @(negedge clk);
            chk($sformatf("vec%0d_fa", i), 32'(bus.ForwardMuxA), 32'(tbl[i].fa));
            chk($sformatf("vec%0d_fb", i), 32'(bus.ForwardMuxB), 32'(tbl[i].fb));
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(tbl[i].st));
            chk($sformatf("vec%0d_bubble", i), 32'(bus.bubble), 32'(tbl[i].bub));
            step();
        end
        chk("vec_stall_cnt", 32'(bus.stall_cnt), 1);
        chk("vec_flush_cnt", 32'(bus.flush_cnt), 2);

        // Stall counter saturation: 20 load-use events.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(mk(3, 1, 0), 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
            step();
            drive(mk(4, 3, 2), 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
            step();
            step();
        end
        chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'(CNT_MAX));
        chk("sat_flush_cnt", 32'(bus.flush_cnt), 0);

        // Asynchronous reset asserted while a load-use stall is showing.
        do_reset();
        drive(mk(3, 1, 0), 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
        step();
        drive(mk(4, 3, 2), 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        #2;
        chk("arst_pre_stall", 32'(bus.stall), 1);
        chk("arst_pre_cnt", 32'(bus.stall_cnt), 0);
        reset = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.stall), 0);
        chk("arst_bubble", 32'(bus.bubble), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle("arst_release");

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic rw;
            rw = 1'($urandom_range(0, 3) != 0);
            drive(mk(rreg(), rreg(), rreg()), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                  rw, rw & 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 9) == 0));
            @(negedge clk);
            model_check(c);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
